io_port_responder: RTL and testbench
====================================

// Module: io_port_responder
// PURPOSE
//  Device-side responder for the CPU I/O instructions issued by the multicycle control unit.
//  'out' asserts OutputWrite for one cycle: this block captures the register value into an
//  output FIFO and drains it to an external device over a valid/ready link.
//  'in' asserts InRead for one cycle while RegWrite selects MemtoReg=2'b10: this block
//  presents InData from a one-entry holding register that an external device fills over valid/ready.
//  Sits between the datapath (register-file read port / MemtoReg mux input 2) and the board I/O.
// PARAMETERS
//  DATA_W     16  width of CPU data and external I/O data
//  OUT_DEPTH  4   output FIFO entries; power of 2, >=2
//  PTR_W      2   log2(OUT_DEPTH); must match OUT_DEPTH
// PORTS
//  CLK        in   1       system clock, rising edge
//  Reset      in   1       asynchronous, active-high
//  OutputWrite in  1       CPU strobe from 'out' state: push OutData
//  OutData    in   DATA_W  register-file value to emit
//  InRead     in   1       CPU strobe from 'in' state: consume held input
//  InData     out  DATA_W  held input value to MemtoReg mux input 2'b10
//  in_avail   out  1       holding register occupied
//  out_full   out  1       output FIFO holds OUT_DEPTH entries
//  out_valid  out  1       external output data valid
//  out_data   out  DATA_W  external output data (FIFO head)
//  out_ready  in   1       external device accepts out_data
//  in_valid   in   1       external device offers in_data
//  in_data    in   DATA_W  external input data
//  in_ready   out  1       block accepts in_data
// BEHAVIOUR
//  Reset (async, any cycle): FIFO count/pointers 0, holding register empty and 0;
//   out_valid=0, out_data=0, out_full=0, in_ready=1, in_avail=0, InData=0. Mid-transfer data is discarded.
//  Output FIFO: push = OutputWrite & !out_full; pop = out_valid & out_ready; both evaluated on registered count.
//   out_valid = (count!=0); out_data = mem[rd_ptr] (0 when empty); out_full = (count==OUT_DEPTH).
//   Latency: OutputWrite sampled at edge k -> out_valid=1 and out_data valid after edge k.
//   Pointers wrap modulo OUT_DEPTH; count is PTR_W+1 bits.
//   Push+pop same edge: count unchanged, both pointers advance (legal at any count except full-push).
//   Push while full: data dropped, FIFO unchanged (CPU has no stall; software polls out_full).
//   Push while empty and out_ready=1: no same-cycle bypass; word appears next cycle.
//   out_data must hold stable while out_valid & !out_ready.
//  Input holding register, two states EMPTY/FULL:
//   EMPTY: in_ready=1; in_valid at edge -> capture in_data, go FULL.
//   FULL: in_ready=0, in_avail=1, InData=held value; InRead at edge -> go EMPTY.
//   InRead in EMPTY: InData=last consumed value (0 after reset), no state change.
//   InRead and in_valid same edge in FULL: only the read happens; new word accepted next cycle at earliest.
//   InData is stable throughout the CPU 'in' state (no combinational path from in_data).
// CONFIGURATION
//  IO_ERR_FLAGS_EN defined: adds ports err_clr (in,1), err_ovf (out,1), err_unf (out,1).
//   err_ovf sets sticky on push-while-full; err_unf sets sticky on InRead-while-EMPTY;
//   err_clr clears both at the edge; when err_clr coincides with a set event, set wins. Reset value 0.
//  Undefined: ports absent, faulting events silently ignored as above.
// TESTING
//  Reset mid-drain (count=3) -> next cycle out_valid=0, out_full=0, in_ready=1, InData=0.
//  out_ready=0, OutputWrite x5 with 0x0001..0x0005 -> out_full=1 after 4th; 0x0005 dropped;
//   then out_ready=1 -> out_data 0x0001,0x0002,0x0003,0x0004 on consecutive cycles, then out_valid=0.
//  Count=2, OutputWrite=0x00AA and pop same edge -> count stays 2, 0x00AA emerges third.
//  in_valid=1 in_data=0xBEEF -> next cycle in_avail=1,in_ready=0,InData=0xBEEF;
//   InRead=1 with in_valid=1 in_data=0x1234 -> EMPTY, then 0x1234 captured one cycle later.
//  Pointer wrap: 10 push/pop pairs at OUT_DEPTH=4 -> data order preserved, no loss.
//  IO_ERR_FLAGS_EN: push-while-full -> err_ovf=1; InRead while EMPTY -> err_unf=1;
//   err_clr together with new overflow -> err_ovf stays 1.

Source files
------------

// File: rtl/io_port_responder.sv
// ---------------------------------------------------------------------------
// io_port_responder
//
// Device-side responder for the CPU 'out' and 'in' I/O instructions.
//
// Output path
//   OutputWrite pushes OutData into an OUT_DEPTH-entry FIFO. The FIFO drains
//   to an external device over out_valid / out_ready. A push while the FIFO
//   is full drops the word, because the CPU cannot stall. Software polls
//   out_full to avoid this.
//
// Input path
//   A one-entry holding register (EMPTY/FULL) is filled by the external
//   device over in_valid / in_ready. The CPU consumes it with InRead.
//   InData always comes from the register and has no combinational path
//   from in_data.
//
// Ports
//   CLK          in   1       system clock, rising edge
//   Reset        in   1       asynchronous, active-high
//   OutputWrite  in   1       push OutData
//   OutData      in   DATA_W  value to emit
//   InRead       in   1       consume held input
//   InData       out  DATA_W  held (or last consumed) input value
//   in_avail     out  1       holding register occupied
//   out_full     out  1       output FIFO full
//   out_valid    out  1       external output data valid
//   out_data     out  DATA_W  FIFO head (0 when empty)
//   out_ready    in   1       external device accepts out_data
//   in_valid     in   1       external device offers in_data
//   in_data      in   DATA_W  external input data
//   in_ready     out  1       holding register can accept in_data
//   err_clr      in   1       (IO_ERR_FLAGS_EN) clear sticky error flags
//   err_ovf      out  1       (IO_ERR_FLAGS_EN) sticky: push while full
//   err_unf      out  1       (IO_ERR_FLAGS_EN) sticky: InRead while empty
//
// Build option: define IO_ERR_FLAGS_EN to add the sticky error-flag ports.
// ---------------------------------------------------------------------------
module io_port_responder #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4,
    parameter int PTR_W     = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              OutputWrite,
    input  logic [DATA_W-1:0] OutData,
    input  logic              InRead,
    output logic [DATA_W-1:0] InData,
    output logic              in_avail,
    output logic              out_full,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready
`ifdef IO_ERR_FLAGS_EN
    ,
    input  logic              err_clr,
    output logic              err_ovf,
    output logic              err_unf
`endif
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(OUT_DEPTH);

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [OUT_DEPTH];
    logic [DATA_W-1:0] mem_d [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push, pop;

    // Both strobes are derived from the registered count, so a push and a
    // pop on the same edge never see each other's effect.
    assign out_valid = (count_q != '0);
    assign out_full  = (count_q == FULL_CNT);
    assign push      = OutputWrite & ~out_full;
    assign pop       = out_valid & out_ready;

    // The head is forced to 0 when the FIFO is empty, so the storage array
    // itself needs no reset. While stalled, the head cannot change: rd_ptr
    // holds, and a push never targets the head slot unless the FIFO is full,
    // which blocks the push.
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = OutData;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Input holding register
    // ------------------------------------------------------------------
    hold_state_t       hold_state_q, hold_state_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            hold_state_q <= HOLD_EMPTY;
            hold_data_q  <= '0;
        end else begin
            hold_state_q <= hold_state_d;
            hold_data_q  <= hold_data_d;
        end
    end

    // The data register is never cleared on a read. After a read it still
    // holds the last consumed word, which is what InData must show in EMPTY.
    always_comb begin
        hold_state_d = hold_state_q;
        hold_data_d  = hold_data_q;
        in_ready     = 1'b0;
        in_avail     = 1'b0;
        case (hold_state_q)
            HOLD_EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_data_d  = in_data;
                    hold_state_d = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                in_avail = 1'b1;
                // in_ready is low here, so a word offered alongside InRead
                // waits until the register is EMPTY on the next cycle.
                if (InRead) begin
                    hold_state_d = HOLD_EMPTY;
                end
            end
            default: begin
                hold_state_d = HOLD_EMPTY;
            end
        endcase
    end

    assign InData = hold_data_q;

`ifdef IO_ERR_FLAGS_EN
    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic err_ovf_q, err_ovf_d;
    logic err_unf_q, err_unf_d;

    // Apply the clear first so that a coincident set event wins.
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        if (err_clr) begin
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
        end
        if (OutputWrite && out_full) begin
            err_ovf_d = 1'b1;
        end
        if (InRead && (hold_state_q == HOLD_EMPTY)) begin
            err_unf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;
`endif

endmodule

// File: tb/tb_io_port_responder.sv
module tb_io_port_responder;

    localparam int DATA_W = 16;

    logic              CLK = 1'b0;
    logic              Reset;
    logic              OutputWrite;
    logic [DATA_W-1:0] OutData;
    logic              InRead;
    logic [DATA_W-1:0] InData;
    logic              in_avail;
    logic              out_full;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
`ifdef IO_ERR_FLAGS_EN
    logic              err_clr;
    logic              err_ovf;
    logic              err_unf;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] sb [$];

    io_port_responder #(.DATA_W(DATA_W), .OUT_DEPTH(4), .PTR_W(2)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .OutputWrite(OutputWrite),
        .OutData    (OutData),
        .InRead     (InRead),
        .InData     (InData),
        .in_avail   (in_avail),
        .out_full   (out_full),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready)
`ifdef IO_ERR_FLAGS_EN
        ,
        .err_clr    (err_clr),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: pops one expected word per accepted handshake and compares.
    // It also checks that the head holds steady across stall cycles.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    logic [DATA_W-1:0] exp_word;
    always @(negedge CLK) begin
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid)
                check("stall_hold", {16'h0, out_data}, {16'h0, prev_data});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", {16'h0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_word = sb.pop_front();
                    check("out_data", {16'h0, out_data}, {16'h0, exp_word});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; OutputWrite = 1'b0; OutData = '0; InRead = 1'b0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef IO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        tick(); tick();
        Reset = 1'b0;
        tick();

        // Reset state
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_full",  {31'h0, out_full},  32'h0);
        check("rst_in_ready",  {31'h0, in_ready},  32'h1);
        check("rst_in_avail",  {31'h0, in_avail},  32'h0);
        check("rst_InData",    {16'h0, InData},    32'h0);
        check("rst_out_data",  {16'h0, out_data},  32'h0);

        // InRead while EMPTY: no state change, InData stays 0
        InRead = 1'b1; tick(); InRead = 1'b0;
        check("unf_in_avail", {31'h0, in_avail}, 32'h0);
        check("unf_InData",   {16'h0, InData},   32'h0);

        // Input capture, hold while FULL, read together with a new offer
        in_valid = 1'b1; in_data = 16'hBEEF; tick();
        check("cap_in_avail", {31'h0, in_avail}, 32'h1);
        check("cap_in_ready", {31'h0, in_ready}, 32'h0);
        check("cap_InData",   {16'h0, InData},   32'hBEEF);
        in_data = 16'h5555; tick();
        check("full_hold_InData", {16'h0, InData}, 32'hBEEF);
        in_data = 16'h1234; InRead = 1'b1; tick(); InRead = 1'b0;
        check("rd_in_avail", {31'h0, in_avail}, 32'h0);
        check("rd_in_ready", {31'h0, in_ready}, 32'h1);
        check("rd_InData",   {16'h0, InData},   32'hBEEF);
        tick(); in_valid = 1'b0;
        check("cap2_in_avail", {31'h0, in_avail}, 32'h1);
        check("cap2_InData",   {16'h0, InData},   32'h1234);

        // Fill with out_ready=0: five pushes, the fifth is dropped
        for (int i = 1; i <= 5; i++) begin
            OutputWrite = 1'b1; OutData = DATA_W'(i);
            if (i <= 4) sb.push_back(DATA_W'(i));
            tick();
            if (i == 1) check("lat_out_valid", {31'h0, out_valid}, 32'h1);
            check($sformatf("fill_full_%0d", i), {31'h0, out_full}, (i >= 4) ? 32'h1 : 32'h0);
        end
        OutputWrite = 1'b0;
        check("fill_head", {16'h0, out_data}, 32'h0001);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid_%0d", i), {31'h0, out_valid}, 32'h1);
            tick();
        end
        check("drain_empty", {31'h0, out_valid}, 32'h0);
        check("drain_out_data0", {16'h0, out_data}, 32'h0);

        // Push and pop on the same edge at count 2
        out_ready = 1'b0;
        OutputWrite = 1'b1; OutData = 16'h0011; sb.push_back(16'h0011); tick();
        OutData = 16'h0022; sb.push_back(16'h0022); tick();
        out_ready = 1'b1; OutData = 16'h00AA; sb.push_back(16'h00AA); tick();
        OutputWrite = 1'b0;
        check("pp_valid_a", {31'h0, out_valid}, 32'h1);
        tick();
        check("pp_valid_b", {31'h0, out_valid}, 32'h1);
        tick();
        check("pp_empty", {31'h0, out_valid}, 32'h0);

        // Pointer wrap: 10 back-to-back push/pop pairs
        for (int i = 0; i < 10; i++) begin
            OutputWrite = 1'b1; OutData = DATA_W'(16'h0100 + i);
            sb.push_back(DATA_W'(16'h0100 + i));
            tick();
        end
        OutputWrite = 1'b0;
        tick(); tick();
        check("wrap_empty", {31'h0, out_valid}, 32'h0);
        check("wrap_sb_drained", sb.size(), 32'h0);

`ifdef IO_ERR_FLAGS_EN
        // Error flags
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            OutputWrite = 1'b1; OutData = DATA_W'(16'h0200 + i);
            sb.push_back(DATA_W'(16'h0200 + i));
            tick();
        end
        check("err_ovf_clear", {31'h0, err_ovf}, 32'h0);
        OutData = 16'hDEAD; tick();
        OutputWrite = 1'b0;
        check("err_ovf_set", {31'h0, err_ovf}, 32'h1);
        InRead = 1'b1; tick(); InRead = 1'b0;   // consumes 0x1234
        InRead = 1'b1; tick(); InRead = 1'b0;   // now EMPTY: underflow
        check("err_unf_set", {31'h0, err_unf}, 32'h1);
        err_clr = 1'b1; OutputWrite = 1'b1; OutData = 16'hDEAD; tick();
        err_clr = 1'b0; OutputWrite = 1'b0;
        check("err_clr_ovf_wins", {31'h0, err_ovf}, 32'h1);
        check("err_clr_unf",      {31'h0, err_unf}, 32'h0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("err_clr_ovf", {31'h0, err_ovf}, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("err_sb_drained", sb.size(), 32'h0);
        in_valid = 1'b1; in_data = 16'h1234; tick(); in_valid = 1'b0;
`endif

        // Reset mid-drain at count 3
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            OutputWrite = 1'b1; OutData = DATA_W'(16'h0300 + i); tick();
        end
        OutputWrite = 1'b0;
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        check("pre_rst_InData", {16'h0, InData}, 32'h1234);
        out_ready = 1'b1;
        #2;
        Reset = 1'b1;
        sb.delete();
        #1;
        check("arst_out_valid", {31'h0, out_valid}, 32'h0);
        tick();
        Reset = 1'b0;
        tick();
        check("mrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("mrst_out_full",  {31'h0, out_full},  32'h0);
        check("mrst_in_ready",  {31'h0, in_ready},  32'h1);
        check("mrst_InData",    {16'h0, InData},    32'h0);
        check("mrst_in_avail",  {31'h0, in_avail},  32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
